// File: rtl/shared_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shared_mem_pkg
//  Description : Shared definitions for the multi-channel shared data memory.
//                Default geometry, the per-channel request bundle for the
//                default geometry, and the round-robin pointer increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package shared_mem_pkg;

    localparam int c_DEF_WIDTH      = 16;
    localparam int c_DEF_ADDR_WIDTH = 8;
    localparam int c_DEF_CHANNELS   = 2;

    // One channel's access fields, sized for the default geometry.
    typedef struct packed {
        logic                        we;
        logic [c_DEF_ADDR_WIDTH-1:0] addr;
        logic [c_DEF_WIDTH-1:0]      wdata;
    } chan_req_t;

    // Wrap-around increment of a round-robin pointer over n entries.
    function automatic int next_ptr(input int cur, input int n);
        if (cur + 1 >= n) begin
            return 0;
        end
        return cur + 1;
    endfunction

endpackage : shared_mem_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin arbiter. Grants the first requester at or
//                after the priority pointer, wrapping. The pointer moves to
//                one past the granted index whenever advance is high.
//  Ports       : clk     - rising-edge clock
//                rst     - asynchronous active-low reset
//                req     - per-requester request
//                advance - the current grant is being accepted this edge
//                gnt     - one-hot grant (combinational, zero in reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import shared_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [N-1:0]       w_gnt;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic               w_found;

    // Two passes give the wrap: first scan indices at or above the pointer,
    // then fall back to the whole vector from index 0.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (i >= int'(r_ptr))) begin
                w_gnt[i]  = 1'b1;
                w_gnt_idx = c_PTR_W'(i);
                w_found   = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                w_gnt[i]  = 1'b1;
                w_gnt_idx = c_PTR_W'(i);
                w_found   = 1'b1;
            end
        end
        if (!rst) begin
            w_gnt = '0;
        end
    end

    assign gnt = w_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= c_PTR_W'(next_ptr(int'(w_gnt_idx), N));
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/shared_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : shared_data_memory
//  Description : Word-addressed memory shared by CHANNELS cores through a
//                round-robin arbiter. One access per cycle; writes commit at
//                the accepting edge, reads return on the requesting channel
//                one cycle later with a single-cycle rvalid pulse.
//  Ports       : clk    - rising-edge clock
//                rst    - asynchronous active-low reset
//                req    - per-channel request
//                we     - per-channel write enable (1 write, 0 read)
//                addr   - per-channel word address, channel i at [i*AW +: AW]
//                wdata  - per-channel write data, channel i at [i*W +: W]
//                gnt    - one-hot grant, combinational
//                rvalid - per-channel read-data-valid pulse
//                rdata  - per-channel registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_data_memory
    import shared_mem_pkg::*;
#(
    parameter int    WIDTH      = c_DEF_WIDTH,
    parameter int    ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int    CHANNELS   = c_DEF_CHANNELS,
    parameter string MEM_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
    input  logic [CHANNELS*WIDTH-1:0]      wdata,
    output logic [CHANNELS-1:0]            gnt,
    output logic [CHANNELS-1:0]            rvalid,
    output logic [CHANNELS*WIDTH-1:0]      rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      r_mem [c_DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr  [CHANNELS];
    logic [WIDTH-1:0]      w_wdata [CHANNELS];
    logic [CHANNELS-1:0]   w_gnt;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0]      w_sel_wdata;
    logic                  w_sel_we;

    logic [CHANNELS-1:0]   r_rvalid;
    logic [WIDTH-1:0]      r_rdata [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign w_addr[i]                 = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[i]                = wdata[i*WIDTH +: WIDTH];
        assign rdata[i*WIDTH +: WIDTH]   = r_rdata[i];
    end

    rr_arbiter #(
        .N (CHANNELS)
    ) u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    assign gnt      = w_gnt;
    // The grant is a subset of req, so any grant bit is an acceptance.
    assign w_accept = |w_gnt;
    assign rvalid   = r_rvalid;

    // One-hot mux of the winning channel's fields onto the single port.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = w_addr[i];
                w_sel_wdata = w_wdata[i];
                w_sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_sel_we) begin
            r_mem[w_sel_addr] <= w_sel_wdata;
        end
    end

    // Read data is captured only for the accepted read, so each channel's
    // rdata holds until that channel's next accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_rvalid <= w_gnt & ~we;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_gnt[i] && !we[i]) begin
                    r_rdata[i] <= r_mem[w_sel_addr];
                end
            end
        end
    end

endmodule : shared_data_memory
`default_nettype wire

// File: tb/tb_shared_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_data_memory
//  Description : Directed self-checking bench for shared_data_memory. A
//                two-channel instance covers reset, write/read, contention,
//                hold and reset-during-read; a three-channel instance covers
//                pointer wrap. Expected read data is queued by the stimulus
//                and popped by a monitor whenever rvalid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_data_memory;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req, we, gnt, rvalid;
    logic [15:0] addr;
    logic [31:0] wdata, rdata;

    logic [2:0]  req3, we3, gnt3, rvalid3;
    logic [23:0] addr3;
    logic [47:0] wdata3, rdata3;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    shared_data_memory #(
        .WIDTH      (16),
        .ADDR_WIDTH (8),
        .CHANNELS   (2)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    shared_data_memory #(
        .WIDTH      (16),
        .ADDR_WIDTH (8),
        .CHANNELS   (3)
    ) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .req    (req3),
        .we     (we3),
        .addr   (addr3),
        .wdata  (wdata3),
        .gnt    (gnt3),
        .rvalid (rvalid3),
        .rdata  (rdata3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic r, input logic w,
                          input logic [7:0] a, input logic [15:0] d);
        req[ch]          = r;
        we[ch]           = w;
        addr[ch*8 +: 8]  = a;
        wdata[ch*16 +: 16] = d;
    endtask

    task automatic set3(input int ch, input logic r, input logic w,
                        input logic [7:0] a, input logic [15:0] d);
        req3[ch]            = r;
        we3[ch]             = w;
        addr3[ch*8 +: 8]    = a;
        wdata3[ch*16 +: 16] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rvalid[0]) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ch0_unexpected_rvalid: got rvalid=1 rdata=%0h expected no read", rdata[15:0]);
            end else begin
                chk("ch0_rdata", {16'h0, rdata[15:0]}, {16'h0, q0.pop_front()});
            end
        end
        if (rvalid[1]) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ch1_unexpected_rvalid: got rvalid=1 rdata=%0h expected no read", rdata[31:16]);
            end else begin
                chk("ch1_rdata", {16'h0, rdata[31:16]}, {16'h0, q1.pop_front()});
            end
        end
        if (rvalid3 != 3'b000) begin
            checks++;
            errors++;
            $display("FAIL dut3_unexpected_rvalid: got %0b expected 0", rvalid3);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        rst    = 1'b0;
        req    = '0; we = '0; addr = '0; wdata = '0;
        req3   = '0; we3 = '0; addr3 = '0; wdata3 = '0;

        // Reset with both channels requesting writes that must wait.
        set_ch(0, 1'b1, 1'b1, 8'h01, 16'h0001);
        set_ch(1, 1'b1, 1'b1, 8'h02, 16'h0002);
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rst_gnt",    gnt,    32'h0);
            chk("rst_rvalid", rvalid, 32'h0);
            chk("rst_rdata",  rdata,  32'h0);
            chk("rst_gnt3",   gnt3,   32'h0);
        end
        rst = 1'b1;
        #1 chk("first_gnt_ch0", gnt, 32'h1);

        // ch1 held stable while ch0 was served: accepted next.
        tick();
        set_ch(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1 chk("hold_gnt_ch1", gnt, 32'h2);

        // Write then read back on ch0.
        tick();
        set_ch(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_ch(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
        #1 chk("wr_beef_gnt", gnt, 32'h1);

        tick();
        set_ch(0, 1'b1, 1'b0, 8'h10, 16'h0000);
        q0.push_back(16'hBEEF);
        #1 chk("rd_beef_gnt", gnt, 32'h1);

        // ch1 alone: granted although pointer favours it anyway; moves ptr to 0.
        tick();
        set_ch(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 8'h02, 16'h0000);
        q1.push_back(16'h0002);
        #1 chk("rd_ch1_gnt", gnt, 32'h2);

        // Full contention for 8 cycles: grants alternate starting at ch0.
        tick();
        set_ch(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 8'h02, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("contend_gnt", gnt, {30'h0, exp_g});
            if (exp_g == 2'b01) q0.push_back(16'h0001);
            else                q1.push_back(16'h0002);
            tick();
        end
        set_ch(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_ch(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1 chk("idle_gnt", gnt, 32'h0);

        // Write 0x1234, then a read whose rvalid is killed by reset.
        tick();
        set_ch(1, 1'b1, 1'b1, 8'h20, 16'h1234);
        #1 chk("wr_1234_gnt", gnt, 32'h2);
        tick();
        set_ch(1, 1'b1, 1'b0, 8'h20, 16'h0000);
        #1 chk("rd_abort_gnt", gnt, 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ch(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        chk("rst_mid_rvalid", rvalid, 32'h0);
        chk("rst_mid_rdata",  rdata,  32'h0);
        chk("rst_mid_gnt",    gnt,    32'h0);

        // After release ptr is 0: ch0 wins, then ch1; memory survived reset.
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_ch(0, 1'b1, 1'b0, 8'h10, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 8'h20, 16'h0000);
        q0.push_back(16'hBEEF);
        #1 chk("post_rst_gnt_ch0", gnt, 32'h1);
        tick();
        set_ch(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        q1.push_back(16'h1234);
        #1 chk("post_rst_gnt_ch1", gnt, 32'h2);
        tick();
        set_ch(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1 chk("post_rst_idle", gnt, 32'h0);

        // Three channels: ch2 alone, pointer wraps to 0, ch0 then beats ch2.
        tick();
        set3(2, 1'b1, 1'b1, 8'h05, 16'h5555);
        #1 chk("wrap_ch2_gnt", gnt3, 32'h4);
        tick();
        set3(2, 1'b1, 1'b1, 8'h07, 16'h7777);
        set3(0, 1'b1, 1'b1, 8'h06, 16'h6666);
        #1 chk("wrap_ch0_gnt", gnt3, 32'h1);
        tick();
        set3(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1 chk("wrap_ch2b_gnt", gnt3, 32'h4);
        tick();
        set3(1, 1'b1, 1'b1, 8'h08, 16'h8888);
        #1 chk("wrap_ch1_gnt", gnt3, 32'h2);
        tick();
        req3 = '0;
        #1 chk("wrap_idle_gnt", gnt3, 32'h0);

        repeat (3) tick();
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shared_data_memory
`default_nettype wire
